// File: rtl/emif_mon_pkg.sv
// Shared definitions for the EMIF health monitor: channel state codes and helpers.
// Build option: EMIF_MON_STATS_EN adds per-channel saturating fault counters.
package emif_mon_pkg;

  typedef enum logic [1:0] {
    ST_LOCK  = 2'b00,
    ST_CAL   = 2'b01,
    ST_READY = 2'b10,
    ST_FAULT = 2'b11
  } chan_state_e;

  localparam int SYN_PLL  = 0;
  localparam int SYN_SUCC = 1;
  localparam int SYN_FAIL = 2;
  localparam int SYN_HB   = 3;
  localparam int SYN_W    = 4;

  localparam int          FAULT_CNT_W   = 16;
  localparam logic [15:0] FAULT_CNT_MAX = 16'hFFFF;

  // Bits needed for a counter that runs 0..limit-1 (never narrower than one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/emif_mon_chan.sv
// One monitored EMIF channel: input synchronisers, LOCK/CAL/READY/FAULT FSM,
// calibration timer and heartbeat watchdog. EMIF_MON_STATS_EN adds a fault counter.
module emif_mon_chan
  import emif_mon_pkg::*;
#(
  parameter int CAL_TIMEOUT = 100000000,
  parameter int HB_TIMEOUT  = 1000000
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       cal_success_i,
  input  logic       cal_fail_i,
  input  logic       hb_toggle_i,
  input  logic       clr_i,
  input  logic       blink_slow_i,
  input  logic       blink_fast_i,
  output logic [1:0] state_o,
  output logic       led_o
`ifdef EMIF_MON_STATS_EN
  ,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o
`endif
);

  localparam int               CAL_W    = cnt_width(CAL_TIMEOUT);
  localparam int               HB_W     = cnt_width(HB_TIMEOUT);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_TIMEOUT - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TIMEOUT - 1);

  logic [SYN_W-1:0] async_in;
  logic [SYN_W-1:0] sync1_reg;
  logic [SYN_W-1:0] sync2_reg;
  logic             hb_prev_reg;

  chan_state_e      state_reg;
  chan_state_e      state_next;
  logic [CAL_W-1:0] cal_timer_reg;
  logic [HB_W-1:0]  hb_wdog_reg;

  logic pll_s;
  logic succ_s;
  logic fail_s;
  logic hb_edge;
  logic cal_expired;
  logic hb_expired;
  logic state_change;

  assign async_in = {hb_toggle_i, cal_fail_i, cal_success_i, pll_locked_i};

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      hb_prev_reg <= 1'b0;
    end else begin
      sync1_reg   <= async_in;
      sync2_reg   <= sync1_reg;
      hb_prev_reg <= sync2_reg[SYN_HB];
    end
  end

  assign pll_s   = sync2_reg[SYN_PLL];
  assign succ_s  = sync2_reg[SYN_SUCC];
  assign fail_s  = sync2_reg[SYN_FAIL];
  assign hb_edge = sync2_reg[SYN_HB] ^ hb_prev_reg;

  // A heartbeat edge in the same cycle as the limit counts as alive, not as a timeout.
  assign cal_expired  = (cal_timer_reg == CAL_LAST);
  assign hb_expired   = (hb_wdog_reg == HB_LAST) && !hb_edge;
  assign state_change = (state_next != state_reg);

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_reg <= ST_LOCK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOCK: begin
        if (pll_s) state_next = ST_CAL;
      end
      ST_CAL: begin
        if (fail_s)           state_next = ST_FAULT;
        else if (!pll_s)      state_next = ST_LOCK;
        else if (cal_expired) state_next = ST_FAULT;
        else if (succ_s)      state_next = ST_READY;
      end
      ST_READY: begin
        if (fail_s || !pll_s || hb_expired) state_next = ST_FAULT;
      end
      ST_FAULT: begin
        if (clr_i) state_next = ST_LOCK;
      end
      default: state_next = ST_LOCK;
    endcase
  end

  always_comb begin
    state_o = state_reg;
    led_o   = 1'b0;
    case (state_reg)
      ST_LOCK:  led_o = 1'b0;
      ST_CAL:   led_o = blink_slow_i;
      ST_READY: led_o = 1'b1;
      ST_FAULT: led_o = blink_fast_i;
      default:  led_o = 1'b0;
    endcase
  end

  // Both timers restart on any state entry and park at their limit instead of wrapping.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      cal_timer_reg <= '0;
      hb_wdog_reg   <= '0;
    end else if (state_change) begin
      cal_timer_reg <= '0;
      hb_wdog_reg   <= '0;
    end else begin
      if (state_reg == ST_CAL && cal_timer_reg != CAL_LAST) begin
        cal_timer_reg <= cal_timer_reg + CAL_W'(1);
      end
      if (state_reg == ST_READY) begin
        if (hb_edge) begin
          hb_wdog_reg <= '0;
        end else if (hb_wdog_reg != HB_LAST) begin
          hb_wdog_reg <= hb_wdog_reg + HB_W'(1);
        end
      end
    end
  end

`ifdef EMIF_MON_STATS_EN
  logic [FAULT_CNT_W-1:0] fault_cnt_reg;

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      fault_cnt_reg <= '0;
    end else if (state_next == ST_FAULT && state_reg != ST_FAULT &&
                 fault_cnt_reg != FAULT_CNT_MAX) begin
      fault_cnt_reg <= fault_cnt_reg + FAULT_CNT_W'(1);
    end
  end

  assign fault_cnt_o = fault_cnt_reg;
`endif

endmodule

// File: rtl/emif_health_monitor.sv
// Monitors NUM_CH EMIF channels: per-channel FSMs, status LEDs, aggregate flags.
// Build option: EMIF_MON_STATS_EN exposes per-channel fault counters on fault_cnt_o.
module emif_health_monitor
  import emif_mon_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CAL_TIMEOUT = 100000000,
  parameter int HB_TIMEOUT  = 1000000,
  parameter int BLINK_DIV_W = 25
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     pll_locked_i,
  input  logic [NUM_CH-1:0]     cal_success_i,
  input  logic [NUM_CH-1:0]     cal_fail_i,
  input  logic [NUM_CH-1:0]     hb_toggle_i,
  input  logic                  clr_i,
  output logic [2*NUM_CH-1:0]   state_o,
  output logic                  all_ready_o,
  output logic                  any_fault_o,
  output logic [NUM_CH-1:0]     led_o,
  output logic                  alive_led_o
`ifdef EMIF_MON_STATS_EN
  ,
  output logic [16*NUM_CH-1:0]  fault_cnt_o
`endif
);

  logic [BLINK_DIV_W-1:0] blink_cnt_reg;
  logic [NUM_CH-1:0]      ready_vec;
  logic [NUM_CH-1:0]      fault_vec;
  logic                   all_ready_reg;
  logic                   any_fault_reg;

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_DIV_W'(1);
    end
  end

  assign alive_led_o = blink_cnt_reg[BLINK_DIV_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      emif_mon_chan #(
        .CAL_TIMEOUT (CAL_TIMEOUT),
        .HB_TIMEOUT  (HB_TIMEOUT)
      ) u_chan (
        .clk_100       (clk_100),
        .rst_n         (rst_n),
        .pll_locked_i  (pll_locked_i[gi]),
        .cal_success_i (cal_success_i[gi]),
        .cal_fail_i    (cal_fail_i[gi]),
        .hb_toggle_i   (hb_toggle_i[gi]),
        .clr_i         (clr_i),
        .blink_slow_i  (blink_cnt_reg[BLINK_DIV_W-1]),
        .blink_fast_i  (blink_cnt_reg[BLINK_DIV_W-3]),
        .state_o       (state_o[2*gi +: 2]),
        .led_o         (led_o[gi])
`ifdef EMIF_MON_STATS_EN
        ,
        .fault_cnt_o   (fault_cnt_o[16*gi +: 16])
`endif
      );

      assign ready_vec[gi] = (state_o[2*gi +: 2] == ST_READY);
      assign fault_vec[gi] = (state_o[2*gi +: 2] == ST_FAULT);
    end
  endgenerate

  // Aggregates trail state_o by one cycle so they can be used as clean registered flags.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      all_ready_reg <= 1'b0;
      any_fault_reg <= 1'b0;
    end else begin
      all_ready_reg <= &ready_vec;
      any_fault_reg <= |fault_vec;
    end
  end

  assign all_ready_o = all_ready_reg;
  assign any_fault_o = any_fault_reg;

endmodule

// File: tb/tb_emif_health_monitor.sv
// Scoreboard bench for emif_health_monitor (NUM_CH=2, CAL_TIMEOUT=16, HB_TIMEOUT=8, BLINK_DIV_W=4).
// Stimulus queues timed expectations; a negedge monitor compares them when they fall due.
module tb_emif_health_monitor;

  localparam int NUM_CH = 2;

  localparam int F_ST0   = 0;
  localparam int F_ST1   = 1;
  localparam int F_ALLRD = 2;
  localparam int F_ANYF  = 3;
  localparam int F_LED   = 4;
  localparam int F_ALIVE = 5;
  localparam int F_FCNT0 = 6;
  localparam int F_FCNT1 = 7;

  logic                clk_100 = 1'b0;
  logic                rst_n;
  logic [NUM_CH-1:0]   pll_locked;
  logic [NUM_CH-1:0]   cal_success;
  logic [NUM_CH-1:0]   cal_fail;
  logic [NUM_CH-1:0]   hb_toggle = '0;
  logic                clr;
  logic [2*NUM_CH-1:0] state_o;
  logic                all_ready_o;
  logic                any_fault_o;
  logic [NUM_CH-1:0]   led_o;
  logic                alive_led_o;
`ifdef EMIF_MON_STATS_EN
  logic [16*NUM_CH-1:0] fault_cnt_o;
`endif

  emif_health_monitor #(
    .NUM_CH      (NUM_CH),
    .CAL_TIMEOUT (16),
    .HB_TIMEOUT  (8),
    .BLINK_DIV_W (4)
  ) dut (
    .clk_100       (clk_100),
    .rst_n         (rst_n),
    .pll_locked_i  (pll_locked),
    .cal_success_i (cal_success),
    .cal_fail_i    (cal_fail),
    .hb_toggle_i   (hb_toggle),
    .clr_i         (clr),
    .state_o       (state_o),
    .all_ready_o   (all_ready_o),
    .any_fault_o   (any_fault_o),
    .led_o         (led_o),
    .alive_led_o   (alive_led_o)
`ifdef EMIF_MON_STATS_EN
    ,
    .fault_cnt_o   (fault_cnt_o)
`endif
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [NUM_CH-1:0] hb_run = '0;
  int                hb_cnt[NUM_CH];
  int                last_hb[NUM_CH];

  function automatic logic [31:0] sample(input int fld);
    case (fld)
      F_ST0:   return 32'(state_o[1:0]);
      F_ST1:   return 32'(state_o[3:2]);
      F_ALLRD: return 32'(all_ready_o);
      F_ANYF:  return 32'(any_fault_o);
      F_LED:   return 32'(led_o);
      F_ALIVE: return 32'(alive_led_o);
`ifdef EMIF_MON_STATS_EN
      F_FCNT0: return 32'(fault_cnt_o[15:0]);
      F_FCNT1: return 32'(fault_cnt_o[31:16]);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk_at(input int dly, input int fld, input logic [31:0] exp, input string name);
    exp_t e;
    e.at   = cyc + dly;
    e.fld  = fld;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  // Monitor: compares every queued expectation that falls due in this cycle.
  initial begin
    int          i;
    logic [31:0] got;
    forever begin
      @(negedge clk_100);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].at <= cyc) begin
          got = sample(sb[i].fld);
          n_checks++;
          if (got === sb[i].exp) begin
            n_pass++;
            $display("check %-24s cyc=%0d got=%0h", sb[i].name, cyc, got);
          end else begin
            $display("FAIL %-24s cyc=%0d got=%0h expected=%0h", sb[i].name, cyc, got, sb[i].exp);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  // Heartbeat source: toggles each running channel every 4 cycles.
  initial begin
    for (int n = 0; n < NUM_CH; n++) begin
      hb_cnt[n]  = 0;
      last_hb[n] = 0;
    end
    forever begin
      @(posedge clk_100);
      #1;
      for (int n = 0; n < NUM_CH; n++) begin
        if (hb_run[n]) begin
          if (hb_cnt[n] == 3) begin
            hb_toggle[n] = ~hb_toggle[n];
            last_hb[n]   = cyc;
            hb_cnt[n]    = 0;
          end else begin
            hb_cnt[n]++;
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int l;
    int d;
    int c;
    rst_n       = 1'b0;
    pll_locked  = '0;
    cal_success = '0;
    cal_fail    = '0;
    clr         = 1'b0;
    step(3);

    n_checks++;
    if (state_o === 4'b0000) begin
      n_pass++;
      $display("check %-24s cyc=%0d got=%0h", "direct_rst_state", cyc, state_o);
    end else begin
      $display("FAIL %-24s cyc=%0d got=%0h expected=0", "direct_rst_state", cyc, state_o);
    end
    n_checks++;
    if (all_ready_o === 1'b0) begin
      n_pass++;
      $display("check %-24s cyc=%0d got=%0h", "direct_rst_all_ready", cyc, all_ready_o);
    end else begin
      $display("FAIL %-24s cyc=%0d got=%0h expected=0", "direct_rst_all_ready", cyc, all_ready_o);
    end

    // Reset state
    chk_at(0, F_ST0,   0, "rst_st0");
    chk_at(0, F_ST1,   0, "rst_st1");
    chk_at(0, F_ALLRD, 0, "rst_all_ready");
    chk_at(0, F_ANYF,  0, "rst_any_fault");
    chk_at(0, F_LED,   0, "rst_led");
    chk_at(0, F_ALIVE, 0, "rst_alive");
`ifdef EMIF_MON_STATS_EN
    chk_at(0, F_FCNT0, 0, "rst_fcnt0");
`endif

    // Both channels lock, calibrate, and reach READY
    rst_n      = 1'b1;
    pll_locked = 2'b11;
    hb_run     = 2'b11;
    chk_at(2, F_ST0,   0, "ch0_lock_sync_lat");
    chk_at(3, F_ST0,   1, "ch0_cal");
    chk_at(3, F_ST1,   1, "ch1_cal");
    chk_at(7, F_ALIVE, 0, "alive_low_blink7");
    chk_at(8, F_ALIVE, 1, "alive_high_blink8");
    step(5);
    cal_success = 2'b11;
    chk_at(2, F_ST0,   1, "ch0_cal_sync_lat");
    chk_at(3, F_ST0,   2, "ch0_ready");
    chk_at(3, F_ST1,   2, "ch1_ready");
    chk_at(3, F_ALLRD, 0, "all_ready_lag");
    chk_at(4, F_ALLRD, 1, "all_ready");
    chk_at(3, F_LED,   3, "led_ready");
    step(10);
    chk_at(0, F_ANYF, 0, "ready_no_fault");
    chk_at(0, F_ST1,  2, "ch1_ready_hb_ok");

    // Channel 1 heartbeat freezes -> watchdog fault, then clr
    hb_run[1] = 1'b0;
    step(1);
    l = last_hb[1];
    chk_at(l + 10 - cyc, F_ST1,  2, "ch1_hb_before_limit");
    chk_at(l + 11 - cyc, F_ST1,  3, "ch1_hb_fault");
    chk_at(l + 11 - cyc, F_ST0,  2, "ch0_unaffected");
    chk_at(l + 11 - cyc, F_ANYF, 0, "any_fault_lag");
    chk_at(l + 12 - cyc, F_ANYF, 1, "any_fault_hb");
    chk_at(l + 12 - cyc, F_ALLRD, 0, "all_ready_drop");
`ifdef EMIF_MON_STATS_EN
    chk_at(l + 11 - cyc, F_FCNT1, 1, "fcnt1_one");
`endif
    while (cyc < l + 13) step(1);
    clr = 1'b1;
    chk_at(0, F_ST1, 3, "ch1_fault_hold");
    chk_at(1, F_ST1, 0, "ch1_clr_lock");
    chk_at(2, F_ST1, 1, "ch1_relock_cal");
    chk_at(3, F_ST1, 2, "ch1_ready_again");
    hb_run[1] = 1'b1;
    step(1);
    clr = 1'b0;
    step(8);

    // Reset pulse, then ch0 calibrates without success -> timeout
    rst_n       = 1'b0;
    cal_success = 2'b10;
    step(1);
    rst_n = 1'b1;
    d = cyc;
    chk_at(0, F_ST0,   0, "rst2_st0");
    chk_at(0, F_ST1,   0, "rst2_st1");
    chk_at(0, F_ALLRD, 0, "rst2_all_ready");
    chk_at(0, F_ANYF,  0, "rst2_any_fault");
    chk_at(0, F_LED,   0, "rst2_led");
    chk_at(0, F_ALIVE, 0, "rst2_alive");
`ifdef EMIF_MON_STATS_EN
    chk_at(0, F_FCNT1, 0, "rst2_fcnt1");
`endif
    chk_at(3,  F_ST0, 1, "ch0_cal_no_succ");
    chk_at(3,  F_ST1, 1, "ch1_cal_after_rst");
    chk_at(4,  F_ST1, 2, "ch1_ready_after_rst");
    chk_at(18, F_ST0, 1, "ch0_cal_last_cycle");
    chk_at(19, F_ST0, 3, "ch0_cal_timeout");
    chk_at(19, F_ANYF, 0, "any_fault_cal_lag");
    chk_at(20, F_ANYF, 1, "any_fault_cal");
`ifdef EMIF_MON_STATS_EN
    chk_at(18, F_FCNT0, 0, "fcnt0_zero");
    chk_at(19, F_FCNT0, 1, "fcnt0_one");
`endif
    step(9);
    clr = 1'b1;
    chk_at(1, F_ST0, 1, "clr_in_cal_ignored");
    step(1);
    clr = 1'b0;
    while (cyc < d + 22) step(1);

    // cal_success and cal_fail together: CAL must go to FAULT, never READY
    cal_success[0] = 1'b1;
    cal_fail[0]    = 1'b1;
    step(3);
    clr = 1'b1;
    c = cyc;
    chk_at(0, F_ST0,  3, "ch0_fault_pre_clr");
    chk_at(1, F_ST0,  0, "ch0_clr_lock");
    chk_at(1, F_LED,  2, "led_lock_ready");
    chk_at(2, F_ST0,  1, "ch0_cal_both");
    chk_at(3, F_ST0,  3, "ch0_fail_wins");
    chk_at(6, F_ST0,  3, "ch0_never_ready");
    chk_at(3, F_ANYF, 0, "any_fault_cleared");
    chk_at(4, F_ANYF, 1, "any_fault_again");
`ifdef EMIF_MON_STATS_EN
    chk_at(3, F_FCNT0, 2, "fcnt0_two");
`endif
    step(1);
    clr = 1'b0;
    while (cyc < c + 8) step(1);

    // Reset while ch0 sits in FAULT
    chk_at(0, F_ST0, 3, "ch0_fault_before_rst");
    rst_n = 1'b0;
    step(1);
    chk_at(0, F_ST0,   0, "rst3_st0");
    chk_at(0, F_ST1,   0, "rst3_st1");
    chk_at(0, F_ANYF,  0, "rst3_any_fault");
    chk_at(0, F_ALLRD, 0, "rst3_all_ready");
    chk_at(0, F_LED,   0, "rst3_led");
`ifdef EMIF_MON_STATS_EN
    chk_at(0, F_FCNT0, 0, "rst3_fcnt0");
`endif

    n_checks++;
    if (state_o === 4'b0000) begin
      n_pass++;
      $display("check %-24s cyc=%0d got=%0h", "direct_rst3_state", cyc, state_o);
    end else begin
      $display("FAIL %-24s cyc=%0d got=%0h expected=0", "direct_rst3_state", cyc, state_o);
    end
    n_checks++;
    if (any_fault_o === 1'b0) begin
      n_pass++;
      $display("check %-24s cyc=%0d got=%0h", "direct_rst3_any_fault", cyc, any_fault_o);
    end else begin
      $display("FAIL %-24s cyc=%0d got=%0h expected=0", "direct_rst3_any_fault", cyc, any_fault_o);
    end

    rst_n = 1'b1;
    step(4);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %-24s cyc=%0d got=not_reached expected=due_at_%0d", sb[0].name, cyc, sb[0].at);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/emif_health_monitor.md
EMIF_HEALTH_MONITOR -- requirements
Module: emif_health_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of EMIF channels monitored (1..8).
REQ-002 SHALL have parameter CAL_TIMEOUT, default 100000000: max clk_100 cycles allowed for calibration.
REQ-003 SHALL have parameter HB_TIMEOUT, default 1000000: max clk_100 cycles between heartbeat edges while ready.
REQ-004 SHALL have parameter BLINK_DIV_W, default 25: width of the free-running LED blink counter.
REQ-005 SHALL have port clk_100  in  1  sole clock, 100 MHz.
REQ-006 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port pll_locked_i  in  NUM_CH  per-channel EMIF PLL locked, asynchronous.
REQ-008 SHALL have port cal_success_i  in  NUM_CH  per-channel local_cal_success, asynchronous.
REQ-009 SHALL have port cal_fail_i  in  NUM_CH  per-channel local_cal_fail, asynchronous.
REQ-010 SHALL have port hb_toggle_i  in  NUM_CH  per-channel heartbeat bit (user-clock counter MSB), asynchronous.
REQ-011 SHALL have port clr_i  in  1  one-cycle pulse; releases all FAULT channels.
REQ-012 SHALL have port state_o  out  2*NUM_CH  per-channel state code, channel n at [2n+1:2n].
REQ-013 SHALL have port all_ready_o  out  1  all channels READY.
REQ-014 SHALL have port any_fault_o  out  1  at least one channel FAULT.
REQ-015 SHALL have port led_o  out  NUM_CH  per-channel status LED.
REQ-016 SHALL have port alive_led_o  out  1  heartbeat LED of clk_100.
REQ-017 SHALL have port fault_cnt_o  out  16*NUM_CH  per-channel fault counters (present only with EMIF_MON_STATS_EN).

Function
REQ-018 Each asynchronous input bit SHALL pass a 2-flop synchroniser; state_o SHALL reflect an input change 3 cycles after it (2 sync + 1 state register).
REQ-019 Per-channel FSM SHALL use codes LOCK=00, CAL=01, READY=10, FAULT=11.
REQ-020 LOCK -> CAL when synced pll_locked=1; otherwise stay.
REQ-021 CAL -> FAULT on cal_fail=1 or cal timer reaching CAL_TIMEOUT-1; CAL -> LOCK on pll_locked=0; CAL -> READY on cal_success=1 and cal_fail=0.
REQ-022 READY -> FAULT on pll_locked=0, cal_fail=1, or heartbeat watchdog reaching HB_TIMEOUT-1.
REQ-023 FAULT SHALL hold until clr_i=1, then -> LOCK; clr_i SHALL have no effect on other states.
REQ-024 Priority on simultaneous events SHALL be: clr_i (FAULT only) > cal_fail > pll loss > timeout > cal_success.
REQ-025 Heartbeat edge SHALL be XOR of the last two synced hb_toggle samples; an edge SHALL zero the watchdog.
REQ-026 Cal timer and watchdog SHALL zero on every state entry, count only in CAL/READY respectively, never wrap.
REQ-027 led_o[n] SHALL be 0 in LOCK, blink_cnt[BLINK_DIV_W-1] in CAL, 1 in READY, blink_cnt[BLINK_DIV_W-3] in FAULT.
REQ-028 alive_led_o SHALL equal blink_cnt[BLINK_DIV_W-1]; blink_cnt SHALL wrap freely.
REQ-029 all_ready_o and any_fault_o SHALL be registered, one cycle after state_o.

Reset
REQ-030 With rst_n=0 at a clk_100 edge: all FSMs LOCK, state_o=0, all_ready_o=0, any_fault_o=0, led_o=0, alive_led_o=0, timers, blink_cnt, synchronisers and fault_cnt_o=0.
REQ-031 Reset mid-calibration or mid-FAULT SHALL return the channel to LOCK with no fault recorded.

Configuration
REQ-032 With EMIF_MON_STATS_EN defined, each channel SHALL keep a 16-bit counter incremented on every entry to FAULT, saturating at 0xFFFF, not cleared by clr_i.
REQ-033 Without EMIF_MON_STATS_EN, fault_cnt_o and its counters SHALL not exist.

Structure
REQ-034 Package emif_mon_pkg SHALL hold the state enum and its 2-bit codes.
REQ-035 Sub-module emif_mon_chan SHALL implement one channel's synchronisers, FSM, timers and counter; the top SHALL generate NUM_CH instances plus blink counter and aggregation.

Verification (NUM_CH=2, CAL_TIMEOUT=16, HB_TIMEOUT=8, BLINK_DIV_W=4)
REQ-036 pll_locked=11, cal_success=11 after 5 cycles, hb toggling every 4 cycles -> both state_o=10, all_ready_o=1, led_o=11.
REQ-037 ch0 locked, no success for 16 cycles in CAL -> state_o[1:0]=11, any_fault_o=1, fault_cnt ch0=1.
REQ-038 ch1 READY, hb_toggle frozen -> FAULT 8 cycles after last edge +3; clr_i pulse -> LOCK next cycle.
REQ-039 cal_success and cal_fail asserted together in CAL -> FAULT, never READY.
REQ-040 rst_n=0 one cycle while ch0 in FAULT -> all outputs 0; clr_i during CAL -> no state change.
